// File: rtl/mux_sel_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_if
//   Bundle of the request/data/grant signals around the shared 2:1 select mux.
//   slave  : the arbiter side (takes requests and data, drives grants and z)
//   master : the requester/consumer side (drives requests and data)
// Signals
//   req0, req1  requests from requester 0 / 1
//   a, b        requester 0 / 1 data (WIDTH)
//   gnt0, gnt1  registered grants
//   sel         registered mux select (1 = b)
//   z, z_valid  registered mux output and its valid strobe
//   busy        arbiter is not idle
// -----------------------------------------------------------------------------
interface mux_sel_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] z;
  logic             z_valid;
  logic             busy;

  modport slave (
    input  req0, req1, a, b,
    output gnt0, gnt1, sel, z, z_valid, busy
  );

  modport master (
    output req0, req1, a, b,
    input  gnt0, gnt1, sel, z, z_valid, busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//   Two-requester round-robin arbiter for a shared 2:1 select mux
//   (z = a&~sel | b&sel). One requester owns the mux at a time; an owner that
//   keeps requesting while the other waits is preempted after MAX_HOLD
//   consecutive grant cycles. The selected data is registered with a valid
//   strobe one cycle after the grant.
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset, dominates everything
//   bus    mux_sel_arbiter_if.slave: req0/req1/a/b in,
//          gnt0/gnt1/sel/z/z_valid/busy out
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic              clk,
  input  logic              reset,
  mux_sel_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_hold_cnt;
  logic             r_last;        // 1 = requester 1 was granted most recently
  logic [WIDTH-1:0] r_z_p1;
  logic             r_vld_p1;

  logic             w_gnt0;
  logic             w_gnt1;

  assign w_gnt0 = (r_state == G0);
  assign w_gnt1 = (r_state == G1);

  assign bus.gnt0    = w_gnt0;
  assign bus.gnt1    = w_gnt1;
  assign bus.sel     = w_gnt1;
  assign bus.busy    = (r_state != IDLE);
  assign bus.z       = r_z_p1;
  assign bus.z_valid = r_vld_p1;

  // Next-state: direct handover between owners, no idle bubble.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) w_next_state = r_last ? G0 : G1;
        else if (bus.req0)        w_next_state = G0;
        else if (bus.req1)        w_next_state = G1;
      end
      G0: begin
        if (!bus.req0)                              w_next_state = bus.req1 ? G1 : IDLE;
        else if (bus.req1 && r_hold_cnt == HOLD_LIM) w_next_state = G1;
      end
      G1: begin
        if (!bus.req1)                              w_next_state = bus.req0 ? G0 : IDLE;
        else if (bus.req0 && r_hold_cnt == HOLD_LIM) w_next_state = G0;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, hold counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_last     <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        // Every grant change restarts the hold window.
        r_hold_cnt <= '0;
        if (w_next_state == G1)      r_last <= 1'b1;
        else if (w_next_state == G0) r_last <= 1'b0;
      end else if (r_state != IDLE && r_hold_cnt != HOLD_LIM) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end

  // ---- stage p1: capture mux output under the current grant ----
  // z holds its last value when no grant is active; only the strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_z_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_z_p1   <= w_gnt1 ? bus.b : bus.a;
      r_vld_p1 <= 1'b1;
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  logic clk;
  logic reset;
  logic req0, req1;
  logic a, b;

  int total = 0;
  int bad   = 0;

  mux_sel_arbiter_if #(.WIDTH(1)) ifc0 ();
  mux_sel_arbiter_if #(.WIDTH(1)) ifc1 ();

  assign ifc0.req0 = req0;
  assign ifc0.req1 = req1;
  assign ifc0.a    = a;
  assign ifc0.b    = b;
  assign ifc1.req0 = req0;
  assign ifc1.req1 = req1;
  assign ifc1.a    = a;
  assign ifc1.b    = b;

  mux_sel_arbiter #(.WIDTH(1), .MAX_HOLD(4), .CW(3)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc0)
  );

  mux_sel_arbiter #(.WIDTH(1), .MAX_HOLD(1), .CW(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full output check of the MAX_HOLD=4 instance; sel must equal gnt1.
  task automatic chk0(input string tag, input logic g0, input logic g1,
                      input logic zv, input logic z, input logic bsy);
    chk({tag, ".gnt0"},    ifc0.gnt0,    g0);
    chk({tag, ".gnt1"},    ifc0.gnt1,    g1);
    chk({tag, ".sel"},     ifc0.sel,     g1);
    chk({tag, ".z_valid"}, ifc0.z_valid, zv);
    chk({tag, ".z"},       ifc0.z,       z);
    chk({tag, ".busy"},    ifc0.busy,    bsy);
    chk({tag, ".excl"},    ifc0.gnt0 & ifc0.gnt1, 1'b0);
  endtask

  task automatic chk1(input string tag, input logic g0, input logic g1,
                      input logic zv, input logic z);
    chk({tag, ".gnt0"},    ifc1.gnt0,    g0);
    chk({tag, ".gnt1"},    ifc1.gnt1,    g1);
    chk({tag, ".sel"},     ifc1.sel,     g1);
    chk({tag, ".z_valid"}, ifc1.z_valid, zv);
    chk({tag, ".z"},       ifc1.z,       z);
  endtask

  initial begin
    logic [8:0] tie_seq;
    logic [5:0] alt_seq;
    logic       prev_g1;
    logic       exp_z;
    logic       exp_zv;

    // 1 reset with both requests high
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    tick();
    chk0("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2 single requester 0
    reset = 1'b0; req0 = 1'b1; req1 = 1'b0; a = 1'b1; b = 1'b0;
    tick();
    chk0("single.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk0("single.c2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk0("single.c3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    req0 = 1'b0;
    tick();
    chk0("single.drop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk0("single.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3 tie from reset release: G0 x4, G1 x4, G0
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    chk0("tie.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tie_seq = 9'b0_1111_0000;
    prev_g1 = 1'b0;
    exp_z   = 1'b0;
    exp_zv  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk0($sformatf("tie.e%0d", k + 1), ~tie_seq[k], tie_seq[k], exp_zv, exp_z, 1'b1);
      // Data captured at the next edge comes from the owner seen now.
      exp_z   = tie_seq[k] ? b : a;
      exp_zv  = 1'b1;
      prev_g1 = tie_seq[k];
    end

    // 4 release from G1: hand over to requester 1, then drop it
    req0 = 1'b0; b = 1'b1;
    tick();
    chk0("rel.g1a", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // z=a captured under G0
    tick();
    chk0("rel.g1b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // z=b
    req1 = 1'b0;
    tick();
    chk0("rel.idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    b = 1'b0;
    tick();
    chk0("rel.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5 reset on the 2nd cycle of G1
    req1 = 1'b1; b = 1'b1;
    tick();
    chk0("mid.g1c1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk0("mid.g1c2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick();
    chk0("mid.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk0("mid.regrant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6 MAX_HOLD=1 instance alternates every cycle under contention
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    chk1("alt.reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    alt_seq = 6'b10_1010;
    exp_z  = 1'b0;
    exp_zv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1($sformatf("alt.e%0d", k + 1), ~alt_seq[k], alt_seq[k], exp_zv, exp_z);
      exp_z  = alt_seq[k] ? b : a;
      exp_zv = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
